// File: rtl/mips_data_bus_bridge.sv
// ============================================================================
// Module   : mips_data_bus_bridge
// Purpose  : Bridges the single-cycle CPU data port onto a registered
//            request/waitrequest bus, stalling the core via clk_enable.
//            Optional abort-on-timeout is compiled in by DATA_BRIDGE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable_in,
    output logic        cpu_clk_enable,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        bus_error
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_REQ     = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_req;
    logic        w_start;
    logic        w_complete;
    logic        w_abort;
    logic        w_cpu_clk_enable;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_writedata;
    logic [31:0] r_rdbuf;

    assign w_req      = cpu_read | cpu_write;
    assign w_start    = (r_state == S_IDLE) & clk_enable_in & w_req;
    assign w_complete = (r_state == S_REQ) & ~mem_waitrequest;

`ifdef DATA_BRIDGE_TIMEOUT_EN
    logic [15:0] r_timeout_cnt;
    logic        r_bus_error;
    logic        w_unused;

    assign w_abort  = (r_state == S_REQ) & mem_waitrequest & (r_timeout_cnt == c_TO_LAST);
    assign w_unused = ^cpu_address[1:0];

    // Counter only runs while the slave stalls; any exit from REQ clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_cnt <= 16'd0;
            r_bus_error   <= 1'b0;
        end else begin
            if ((r_state == S_REQ) & mem_waitrequest & ~w_abort)
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            else
                r_timeout_cnt <= 16'd0;
            if (w_abort)
                r_bus_error <= 1'b1;
        end
    end

    assign bus_error = r_bus_error;
`else
    logic w_unused;

    assign w_abort   = 1'b0;
    assign bus_error = 1'b0;
    assign w_unused  = ^{cpu_address[1:0], c_TO_LAST};
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start)                w_next_state = S_REQ;
            S_REQ:   if (w_complete | w_abort)   w_next_state = S_DONE;
            S_DONE:  if (clk_enable_in)          w_next_state = S_IDLE;
            default:                             w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_cpu_clk_enable = clk_enable_in &
                           ((r_state == S_DONE) | ((r_state == S_IDLE) & ~w_req));
    end

    // Write takes priority when the CPU raises both strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= 32'd0;
            r_mem_writedata <= 32'd0;
            r_rdbuf         <= 32'd0;
        end else if (w_start) begin
            r_mem_read      <= cpu_read & ~cpu_write;
            r_mem_write     <= cpu_write;
            r_mem_address   <= {cpu_address[31:2], 2'b00};
            r_mem_writedata <= cpu_writedata;
        end else if (w_complete | w_abort) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_abort)
                r_rdbuf <= 32'd0;
            else if (r_mem_read)
                r_rdbuf <= mem_readdata;
        end
    end

    assign cpu_clk_enable = w_cpu_clk_enable;
    assign cpu_readdata   = r_rdbuf;
    assign mem_address    = r_mem_address;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;

endmodule

`default_nettype wire

// File: tb/tb_mips_data_bus_bridge.sv
// ============================================================================
// Module   : tb_mips_data_bus_bridge
// Purpose  : Self-checking bench for mips_data_bus_bridge (vector table,
//            randomized accesses against a transaction-level model, corners).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_data_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable_in;
    logic        cpu_clk_enable;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        bus_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdbuf = 32'd0;
    logic        exp_berr  = 1'b0;

    mips_data_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable_in   (clk_enable_in),
        .cpu_clk_enable  (cpu_clk_enable),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_readdata    (cpu_readdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .bus_error       (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nwait;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdbuf;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete memory instruction with clk_enable_in held high; the slave
    // stalls nwait cycles. Expected behaviour comes from the transaction rules.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int nwait, input logic [31:0] rdata);
        logic [31:0] ealign;
        logic        erd;
        ealign = addr & 32'hFFFF_FFFC;
        erd    = rd & ~wr;
        @(negedge clk);
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wdata;
        clk_enable_in = 1'b1; mem_waitrequest = 1'b1; mem_readdata = $urandom;
        #1;
        chk("idle_req_stall", cpu_clk_enable, 0);
        chk("idle_strobes", {mem_read, mem_write}, 0);
        for (int k = 0; k <= nwait; k++) begin
            @(negedge clk);
            mem_waitrequest = (k < nwait);
            mem_readdata    = (k == nwait) ? rdata : $urandom;
            #1;
            chk("req_stall", cpu_clk_enable, 0);
            chk("req_read", mem_read, erd);
            chk("req_write", mem_write, wr);
            chk("req_addr", mem_address, ealign);
            chk("req_wdata", mem_writedata, wdata);
        end
        if (erd) exp_rdbuf = rdata;
        @(negedge clk);
        mem_waitrequest = $urandom; mem_readdata = $urandom;
        #1;
        chk("done_enable", cpu_clk_enable, 1);
        chk("done_strobes", {mem_read, mem_write}, 0);
        chk("done_rdata", cpu_readdata, exp_rdbuf);
        chk("bus_error", bus_error, exp_berr);
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0;
        #1;
        chk("post_idle_enable", cpu_clk_enable, 1);
        chk("post_idle_strobes", {mem_read, mem_write}, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0000_1006, 32'h0,          0, 32'hCAFE_F00D, 32'h0000_1004, 32'hCAFE_F00D};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 3, 32'hDEAD_BEEF, 32'h0000_2000, 32'hCAFE_F00D};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_300B, 32'hA5A5_A5A5, 1, 32'h1111_1111, 32'h0000_3008, 32'hCAFE_F00D};
        tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,          2, 32'h8765_4321, 32'hFFFF_FFFC, 32'h8765_4321};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          1, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000};
        tbl[5] = '{1'b1, 1'b0, 32'h8000_0001, 32'h0,          3, 32'h0F0F_0F0F, 32'h8000_0000, 32'h0F0F_0F0F};

        reset = 1'b1; clk_enable_in = 1'b1; cpu_address = '0; cpu_read = 1'b0;
        cpu_write = 1'b0; cpu_writedata = '0; mem_waitrequest = 1'b1; mem_readdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_rdata", cpu_readdata, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_enable_hi", cpu_clk_enable, 1);
        clk_enable_in = 1'b0; #1;
        chk("rst_enable_lo", cpu_clk_enable, 0);
        @(negedge clk);
        reset = 1'b0; clk_enable_in = 1'b1;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].nwait, tbl[i].rdata);
            chk("vec_addr", mem_address, tbl[i].exp_addr);
            chk("vec_rdbuf", cpu_readdata, tbl[i].exp_rdbuf);
        end

        // clk_enable_in low: no start in IDLE, REQ still completes, DONE holds
        @(negedge clk);
        cpu_read = 1'b1; cpu_address = 32'h0000_0500; clk_enable_in = 1'b0;
        #1 chk("gate_idle_enable", cpu_clk_enable, 0);
        @(negedge clk); #1;
        chk("gate_no_start", mem_read, 0);
        clk_enable_in = 1'b1;
        @(negedge clk);
        clk_enable_in = 1'b0; mem_waitrequest = 1'b1;
        #1;
        chk("gate_req_read", mem_read, 1);
        chk("gate_req_enable", cpu_clk_enable, 0);
        @(negedge clk);
        mem_waitrequest = 1'b0; mem_readdata = 32'h1357_9BDF;
        exp_rdbuf = 32'h1357_9BDF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_waitrequest = $urandom; mem_readdata = $urandom;
            #1;
            chk("gate_done_enable", cpu_clk_enable, 0);
            chk("gate_done_read", mem_read, 0);
            chk("gate_done_rdata", cpu_readdata, exp_rdbuf);
        end
        @(negedge clk);
        clk_enable_in = 1'b1;
        #1 chk("gate_commit_enable", cpu_clk_enable, 1);
        @(negedge clk);
        cpu_read = 1'b0;
        #1 chk("gate_back_idle", cpu_clk_enable, 1);

        // Randomized accesses against the transaction model
        for (int i = 0; i < 30; i++) begin
            logic rd, wr;
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            access(rd, wr, $urandom, $urandom, $urandom_range(0, 3), $urandom);
            chk("rand_rdbuf", cpu_readdata, exp_rdbuf);
        end

        // Reset during the second REQ cycle
        access(1'b1, 1'b0, 32'h0000_0700, 32'h0, 0, 32'h7777_7777);
        @(negedge clk);
        cpu_read = 1'b1; cpu_address = 32'h0000_0800; mem_waitrequest = 1'b1;
        @(negedge clk); #1;
        chk("rstreq_read_1", mem_read, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; cpu_read = 1'b0;
        exp_rdbuf = 32'd0; exp_berr = 1'b0;
        #1;
        chk("rstreq_read_0", mem_read, 0);
        chk("rstreq_rdata", cpu_readdata, 0);
        chk("rstreq_idle", cpu_clk_enable, 1);

`ifdef DATA_BRIDGE_TIMEOUT_EN
        // Stuck slave: abort after 4 wait cycles
        access(1'b1, 1'b0, 32'h0000_0900, 32'h0, 1, 32'h55AA_55AA);
        @(negedge clk);
        cpu_read = 1'b1; cpu_address = 32'h0000_0040; mem_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("to_req_read", mem_read, 1);
            chk("to_req_berr", bus_error, 0);
        end
        @(negedge clk); #1;
        chk("to_done_read", mem_read, 0);
        chk("to_done_berr", bus_error, 1);
        chk("to_done_rdata", cpu_readdata, 0);
        chk("to_done_enable", cpu_clk_enable, 1);
        exp_rdbuf = 32'd0; exp_berr = 1'b1;
        @(negedge clk);
        cpu_read = 1'b0;
        access(1'b1, 1'b0, 32'h0000_0A00, 32'h0, 2, 32'h2468_ACE0);
        chk("to_sticky_berr", bus_error, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
